// File: rtl/sha512_pad_pkg.sv
// Shared types and constants for the SHA-512 message padder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha512_pad_pkg;

  localparam int SHA512_BLOCK_W = 1024;
  localparam int SHA512_WORD_W  = 64;
  localparam int SHA512_WORDS   = 16;

  localparam logic [SHA512_WORD_W-1:0] SHA512_MARKER = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } pad_state_e;

endpackage

// File: rtl/sha512_pad_lastword.sv
// Keeps the first n bytes of a big-endian word, places the 0x80 marker in byte n
// (when n<8) and zeroes the rest. Latency: purely combinational.
// Backpressure: none; the caller decides when the result is stored.
// Ports: data_i (64b word), bytes_i (valid byte count, 0..8), word_o (masked word).
module sha512_pad_lastword
  import sha512_pad_pkg::*;
(
  input  logic [SHA512_WORD_W-1:0] data_i,
  input  logic [3:0]               bytes_i,
  output logic [SHA512_WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(bytes_i)) begin
        word_o[SHA512_WORD_W-1-8*b -: 8] = data_i[SHA512_WORD_W-1-8*b -: 8];
      end else if (b == int'(bytes_i)) begin
        word_o[SHA512_WORD_W-1-8*b -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha512_msg_padder.sv
// Packs a 64-bit big-endian word stream into FIPS 180-4 padded 1024-bit blocks.
// Latency: 16th word accepted in cycle N -> block valid in N+1; final block follows
// the last word after (14-idx) PAD + 1 LEN cycles. Backpressure: in_ready_o is low
// outside FILL; a presented block holds steady until out_ready_i takes it.
// Ports: clk_i/rst_i (async, active-high); in_valid_i/in_ready_o/in_data_i/in_last_i/
// in_bytes_i word input; out_valid_o/out_ready_i/out_block_o/out_first_o/out_last_o
// block output; err_o sticky protocol error.
// Build option: define SHA512_PADDER_LEN128_EN for a full 128-bit length counter.
module sha512_msg_padder
  import sha512_pad_pkg::*;
#(
`ifdef SHA512_PADDER_LEN128_EN
  parameter int MAX_LEN_W = 128
`else
  parameter int MAX_LEN_W = 64
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [SHA512_WORD_W-1:0]  in_data_i,
  input  logic                      in_last_i,
  input  logic [3:0]                in_bytes_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SHA512_BLOCK_W-1:0] out_block_o,
  output logic                      out_first_o,
  output logic                      out_last_o,
  output logic                      err_o
);

  pad_state_e state_q, state_d;

  logic [SHA512_WORDS-1:0][SHA512_WORD_W-1:0] buf_q, buf_d;
  logic [3:0]           idx_q, idx_d;
  logic [MAX_LEN_W-1:0] len_q, len_d;
  logic                 first_q, first_d;   // next emitted block opens a message
  logic                 mark_q, mark_d;     // 0x80 marker still owed (last word was full)
  logic                 tail_q, tail_d;     // length did not fit; a zero/length block follows
  logic                 last_q, last_d;     // block being emitted closes the message
  logic                 err_q, err_d;

  logic [3:0]               n_eff;
  logic [SHA512_WORD_W-1:0] masked_word;

  // Out-of-range counts are treated as a full word after flagging the error.
  assign n_eff = (in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i;

  sha512_pad_lastword u_lastword (
    .data_i  (in_data_i),
    .bytes_i (n_eff),
    .word_o  (masked_word)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    len_d       = len_q;
    first_d     = first_q;
    mark_d      = mark_q;
    tail_d      = tail_q;
    last_d      = last_q;
    err_d       = err_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_first_o = 1'b0;
    out_last_o  = 1'b0;

    unique case (state_q)
      FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if ((!in_last_i && in_bytes_i != 4'd8) || in_bytes_i > 4'd8) begin
            err_d = 1'b1;
          end
          buf_d[idx_q] = masked_word;
          len_d        = len_q + MAX_LEN_W'({n_eff, 3'b000});
          if (!in_last_i) begin
            if (idx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else if (n_eff == 4'd8) begin
            // Full last word: the marker goes into the next slot, possibly the next block.
            mark_d = 1'b1;
            if (idx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
              tail_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = PAD;
            end
          end else begin
            if (idx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
              tail_d  = 1'b1;
            end else if (idx_q == 4'd13) begin
              // Marker already in word 13; words 14/15 are free for the length.
              idx_d   = 4'd14;
              state_d = LEN;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = PAD;
            end
          end
        end
      end

      PAD: begin
        buf_d[idx_q] = mark_q ? SHA512_MARKER : '0;
        mark_d       = 1'b0;
        if (idx_q == 4'd15) begin
          state_d = EMIT;
          last_d  = 1'b0;
          tail_d  = 1'b1;
        end else if (idx_q == 4'd13) begin
          idx_d   = 4'd14;
          state_d = LEN;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      LEN: begin
`ifdef SHA512_PADDER_LEN128_EN
        buf_d[14] = len_q[127:64];
        buf_d[15] = len_q[63:0];
`else
        buf_d[14] = '0;
        buf_d[15] = SHA512_WORD_W'(len_q);
`endif
        state_d = EMIT;
        last_d  = 1'b1;
      end

      EMIT: begin
        out_valid_o = 1'b1;
        out_first_o = first_q;
        out_last_o  = last_q;
        if (out_ready_i) begin
          first_d = last_q;
          idx_d   = '0;
          buf_d   = '0;
          if (tail_q) begin
            tail_d  = 1'b0;
            state_d = PAD;
          end else begin
            state_d = FILL;
            if (last_q) begin
              len_d = '0;
            end
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      mark_q  <= 1'b0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      first_q <= first_d;
      mark_q  <= mark_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Word 0 sits in the most significant bits of the block.
  always_comb begin
    out_block_o = '0;
    for (int i = 0; i < SHA512_WORDS; i++) begin
      out_block_o[SHA512_BLOCK_W-1-i*SHA512_WORD_W -: SHA512_WORD_W] = buf_q[i];
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_sha512_msg_padder.sv
// Bench for sha512_msg_padder: random message streams scored against a byte-level
// FIPS 180-4 padding model, plus directed reset, backpressure and error scenarios.
module tb_sha512_msg_padder;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [63:0]   in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic [3:0]    in_bytes_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [1023:0] out_block_o;
  logic          out_first_o;
  logic          out_last_o;
  logic          err_o;

  sha512_msg_padder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_bytes_i  (in_bytes_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_block_o (out_block_o),
    .out_first_o (out_first_o),
    .out_last_o  (out_last_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] dat;
    logic        last;
    logic [3:0]  nb;
  } word_t;

  typedef struct packed {
    logic [1023:0] blk;
    logic          first;
    logic          last;
  } blk_t;

  word_t         words_q[$];
  blk_t          exp_q[$];
  logic [1023:0] got_q[$];
  logic [7:0]    msg[$];
  blk_t          last_got;
  int            hold_cycles;
  int            total = 0;
  int            bad = 0;

  task automatic do_reset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Split msg into input words (garbage in unused bytes) and append the
  // expected padded blocks computed straight from the padding definition.
  task automatic push_msg(input bit zero_tail);
    int         n;
    int         pos;
    int         rem;
    int         nblk;
    word_t      w;
    blk_t       e;
    logic [7:0] p[$];
    logic [127:0] bitlen;
    n   = msg.size();
    pos = 0;
    forever begin
      rem   = n - pos;
      w.dat = {$urandom(), $urandom()};
      if (rem > 8 || (rem == 8 && zero_tail)) begin
        for (int b = 0; b < 8; b++) w.dat[63-8*b -: 8] = msg[pos+b];
        w.last = 1'b0;
        w.nb   = 4'd8;
        pos    = pos + 8;
        words_q.push_back(w);
      end else begin
        for (int b = 0; b < rem; b++) w.dat[63-8*b -: 8] = msg[pos+b];
        w.last = 1'b1;
        w.nb   = 4'(rem);
        words_q.push_back(w);
        break;
      end
    end
    for (int i = 0; i < n; i++) p.push_back(msg[i]);
    p.push_back(8'h80);
    while ((p.size() % 128) != 112) p.push_back(8'h00);
    bitlen = 128'(n) * 128'd8;
    for (int i = 0; i < 16; i++) p.push_back(bitlen[127-8*i -: 8]);
    nblk = p.size() / 128;
    for (int k = 0; k < nblk; k++) begin
      e.blk = '0;
      for (int j = 0; j < 128; j++) e.blk[1023-8*j -: 8] = p[k*128+j];
      e.first = (k == 0);
      e.last  = (k == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(255)));
  endtask

  // Cycle loop: decide inputs on the falling edge, score blocks on handshake.
  task automatic run_traffic(input int stall, input int rdy_pct, input int vld_pct);
    int    cyc;
    int    stall_left;
    bit    hold;
    bit    keep;
    blk_t  held;
    blk_t  e;
    word_t w;
    cyc        = 0;
    stall_left = stall;
    hold       = 1'b0;
    keep       = 1'b0;
    while ((words_q.size() != 0 || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      if (hold) begin
        total++;
        if (out_valid_o !== 1'b1 || out_block_o !== held.blk ||
            out_first_o !== held.first || out_last_o !== held.last) begin
          bad++;
          $display("FAIL hold_stable: valid=%b first=%b last=%b, required valid=1 first=%b last=%b and unchanged block",
                   out_valid_o, out_first_o, out_last_o, held.first, held.last);
        end
      end
      if (out_valid_o === 1'b1) begin
        total++;
        if (in_ready_o !== 1'b0) begin
          bad++;
          $display("FAIL ready_in_emit: in_ready=%b, required 0", in_ready_o);
        end
        if (stall_left > 0) begin
          out_ready_i = 1'b0;
          stall_left--;
        end else begin
          out_ready_i = ($urandom_range(99) < rdy_pct);
        end
        if (out_ready_i) begin
          hold = 1'b0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_block: got block first=%b last=%b, required none", out_first_o, out_last_o);
          end else begin
            e = exp_q.pop_front();
            if (out_block_o !== e.blk || out_first_o !== e.first || out_last_o !== e.last) begin
              bad++;
              $display("FAIL block: got w0=%h w15=%h first=%b last=%b, required w0=%h w15=%h first=%b last=%b",
                       out_block_o[1023:960], out_block_o[63:0], out_first_o, out_last_o,
                       e.blk[1023:960], e.blk[63:0], e.first, e.last);
            end
          end
          last_got = '{out_block_o, out_first_o, out_last_o};
          got_q.push_back(out_block_o);
        end else begin
          hold = 1'b1;
          hold_cycles++;
          held = '{out_block_o, out_first_o, out_last_o};
        end
      end else begin
        hold        = 1'b0;
        out_ready_i = 1'($urandom_range(1));
      end
      if (words_q.size() != 0 && (keep || $urandom_range(99) < vld_pct)) begin
        w          = words_q[0];
        in_valid_i = 1'b1;
        in_data_i  = w.dat;
        in_last_i  = w.last;
        in_bytes_i = w.nb;
        if (in_ready_o === 1'b1) begin
          w    = words_q.pop_front();
          keep = 1'b0;
        end else begin
          keep = 1'b1;
        end
      end else begin
        in_valid_i = 1'b0;
        keep       = 1'b0;
      end
    end
    if (cyc >= 20000) begin
      total++;
      bad++;
      $display("FAIL timeout: words left=%0d blocks left=%0d, required 0", words_q.size(), exp_q.size());
      words_q.delete();
      exp_q.delete();
    end
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || err_o !== 1'b0 ||
        out_first_o !== 1'b0 || out_last_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%b ready=%b err=%b first=%b last=%b, required 0 1 0 0 0",
               out_valid_o, in_ready_o, err_o, out_first_o, out_last_o);
    end
  endtask

  task automatic test_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    push_msg(1'b0);
    run_traffic(0, 100, 100);
    total++;
    if (last_got.blk[1023:960] !== 64'h6162_6380_0000_0000 || last_got.blk[959:64] !== '0 ||
        last_got.blk[63:0] !== 64'h18 || last_got.first !== 1'b1 || last_got.last !== 1'b1) begin
      bad++;
      $display("FAIL abc: w0=%h w15=%h first=%b last=%b, required w0=6162638000000000 w15=18 first=1 last=1",
               last_got.blk[1023:960], last_got.blk[63:0], last_got.first, last_got.last);
    end
  endtask

  task automatic test_empty();
    msg.delete();
    push_msg(1'b0);
    run_traffic(0, 100, 100);
    total++;
    if (last_got.blk[1023:960] !== 64'h8000_0000_0000_0000 || last_got.blk[959:0] !== '0 ||
        last_got.first !== 1'b1 || last_got.last !== 1'b1) begin
      bad++;
      $display("FAIL empty: w0=%h w15=%h first=%b last=%b, required w0=8000000000000000 rest 0 first=1 last=1",
               last_got.blk[1023:960], last_got.blk[63:0], last_got.first, last_got.last);
    end
  endtask

  task automatic test_overflow_tail();
    got_q.delete();
    rand_msg(112);
    push_msg(1'b0);
    run_traffic(0, 100, 100);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL len112_count: got %0d blocks, required 2", got_q.size());
    end else if (got_q[0][127:64] !== 64'h8000_0000_0000_0000 || got_q[0][63:0] !== '0 ||
                 got_q[1][1023:64] !== '0 || got_q[1][63:0] !== 64'h380) begin
      bad++;
      $display("FAIL len112: b1 w14=%h w15=%h b2 w15=%h, required 8000000000000000 0 380",
               got_q[0][127:64], got_q[0][63:0], got_q[1][63:0]);
    end
    got_q.delete();
    rand_msg(128);
    push_msg(1'b0);
    run_traffic(0, 100, 100);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL len128_count: got %0d blocks, required 2", got_q.size());
    end else if (got_q[1][1023:960] !== 64'h8000_0000_0000_0000 || got_q[1][63:0] !== 64'h400) begin
      bad++;
      $display("FAIL len128: b2 w0=%h w15=%h, required 8000000000000000 400",
               got_q[1][1023:960], got_q[1][63:0]);
    end
  endtask

  task automatic test_back_to_back();
    hold_cycles = 0;
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    push_msg(1'b0);
    rand_msg(20);
    push_msg(1'b1);
    run_traffic(10, 100, 100);
    total++;
    if (hold_cycles < 10) begin
      bad++;
      $display("FAIL stall_seen: held %0d cycles, required at least 10", hold_cycles);
    end
  endtask

  task automatic test_random();
    int lens[12] = '{0, 8, 55, 56, 103, 104, 111, 119, 120, 127, 239, 240};
    for (int i = 0; i < 12; i++) begin
      rand_msg(lens[i]);
      push_msg(1'($urandom_range(1)));
    end
    run_traffic(0, 60, 70);
    for (int i = 0; i < 15; i++) begin
      rand_msg($urandom_range(300));
      push_msg(1'($urandom_range(1)));
    end
    run_traffic(0, 50, 80);
  endtask

  task automatic test_rst_mid();
    word_t w;
    for (int i = 0; i < 5; i++) begin
      w = '{{$urandom(), $urandom()}, 1'b0, 4'd8};
      words_q.push_back(w);
    end
    run_traffic(0, 100, 100);
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_fill: valid=%b ready=%b, required 0 1", out_valid_o, in_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    test_abc();
    for (int i = 0; i < 16; i++) begin
      w = '{{$urandom(), $urandom()}, 1'b0, 4'd8};
      words_q.push_back(w);
    end
    run_traffic(0, 0, 100);
    total++;
    if (out_valid_o !== 1'b1 || out_first_o !== 1'b1 || out_last_o !== 1'b0) begin
      bad++;
      $display("FAIL full_block: valid=%b first=%b last=%b, required 1 1 0", out_valid_o, out_first_o, out_last_o);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_emit: valid=%b ready=%b, required 0 1", out_valid_o, in_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    test_abc();
  endtask

  task automatic test_err();
    word_t w;
    w = '{{$urandom(), $urandom()}, 1'b0, 4'd5};
    words_q.push_back(w);
    run_traffic(0, 100, 100);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_short: err=%b, required 1", err_o);
    end
    repeat (5) @(negedge clk_i);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%b, required 1", err_o);
    end
    do_reset();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b, required 0", err_o);
    end
    w = '{{$urandom(), $urandom()}, 1'b0, 4'd9};
    words_q.push_back(w);
    run_traffic(0, 100, 100);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_over8: err=%b, required 1", err_o);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_overflow_tail();
    test_back_to_back();
    test_random();
    test_rst_mid();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha512_msg_padder.md
# sha512_msg_padder

Upstream feeder for the SHA-512 accelerator. It accepts a message as a stream of 64-bit big-endian words, counts its length, and appends the FIPS 180-4 padding: the 0x80 marker, zero fill, and a 128-bit bit-length field. It emits complete 1024-bit blocks over a valid/ready handshake. Each block carries first/last flags, which the downstream control uses to pulse the core's init on the first block and next on every later block.

## Interface
- `MAX_LEN_W`, default 64: width of the internal bit-length counter. It is overridden to 128 by `SHA512_PADDER_LEN128_EN`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. Asynchronous and active-high.
- `in_valid_i`, in, 1: input word valid.
- `in_ready_o`, out, 1: padder can accept a word.
- `in_data_i`, in, 64: message word. The first message byte is in bits [63:56].
- `in_last_i`, in, 1: this word ends the message.
- `in_bytes_i`, in, 4: valid bytes in the word, left-aligned.
  - Must be 8 when `in_last_i` is 0.
  - May be 0..8 when `in_last_i` is 1. A value of 0 on the last word contributes no data.
- `out_valid_o`, out, 1: `out_block_o` is valid.
- `out_ready_i`, in, 1: downstream accepts the block.
- `out_block_o`, out, 1024: padded block. Word 0 occupies [1023:960]; word 15 occupies [63:0].
- `out_first_o`, out, 1: block is the first block of its message.
- `out_last_o`, out, 1: block is the final block of its message.
- `err_o`, out, 1: sticky protocol error. Set when a word with `in_last_i`=0 and `in_bytes_i`≠8 is accepted, or when `in_bytes_i`>8. Cleared only by reset.

## Operation
- Internal storage:
  - block buffer of 16×64 bits;
  - word index `idx` (0..15);
  - bit counter `len`, of width `MAX_LEN_W`;
  - flag `first_pend`;
  - state register.
- States: FILL, PAD, LEN, EMIT.
- FILL
  - `in_ready_o`=1.
  - On each accepted word:
    - Store bytes 0..n-1 of `in_data_i` into `buf[idx]`. For the last word, byte n is set to 0x80 when n<8, and the remaining bytes are zeroed.
    - Update `len += 8*n`. The counter wraps modulo 2^`MAX_LEN_W`.
  - Non-last word: increment `idx`. When `idx` reaches 15, go to EMIT with `last`=0.
  - Last word with n<8 (marker already placed): increment `idx`, then go to PAD.
  - Last word with n=8: increment `idx`, record `marker_pend`=1, then go to PAD.
- PAD
  - `in_ready_o`=0. Writes one word per cycle.
  - The word written is 0x8000_0000_0000_0000 if `marker_pend` (which then clears), otherwise 0.
  - When `idx`==14 and `marker_pend`=0: go to LEN.
  - When the write lands at `idx` 15 (block full, no room for length): go to EMIT with `last`=0 and `tail_pend`=1. After the handshake, return to PAD with `idx`=0.
- LEN
  - One cycle. Writes `buf[14]` = upper 64 bits of the 128-bit length and `buf[15]` = lower 64 bits.
  - Then go to EMIT with `last`=1.
- EMIT
  - `out_valid_o`=1. `out_first_o`=`first_pend`. `out_last_o`=`last`.
  - On `out_valid_o`&&`out_ready_i`: clear `first_pend`, reset `idx` to 0, and clear the buffer.
  - Next state: PAD if `tail_pend`; FILL if not `last`; otherwise FILL with `len`=0 and `first_pend`=1.
- `out_block_o` is driven directly from the buffer and is stable for as long as `out_valid_o` is high.
- Reset values: state=FILL, `idx`=0, `len`=0, buffer=0, `first_pend`=1, `marker_pend`=`tail_pend`=0, `out_valid_o`=0, `in_ready_o`=1 (combinational from state), `err_o`=0.

## Timing
- Peak throughput is one input word per cycle.
- When the 16th word is accepted in cycle N, `out_valid_o` is asserted in cycle N+1.
- `in_ready_o` is low in PAD, LEN and EMIT. The handshake cycle in EMIT does not accept input; FILL resumes in the following cycle.
- Padding latency: from acceptance of the last word to `out_valid_o` of the final block is (14 − `idx`) PAD cycles + 1 LEN cycle + 1. An overflowing tail adds one extra block emit plus 14 PAD cycles.
- `out_valid_o` must not drop, and `out_block_o`/flags must not change, until the handshake completes.
- Asynchronous `rst_i` mid-message or mid-EMIT discards all state. `out_valid_o` falls immediately.

## Configuration
- `SHA512_PADDER_LEN128_EN` defined: `len` is a full 128-bit counter, and the length words carry all 128 bits.
- Not defined: `len` is 64 bits, `buf[14]` is always 0, and messages of 2^64 bits or longer wrap silently.

## Structure
- Package `sha512_pad_pkg` holds:
  - state enum `pad_state_e` (FILL, PAD, LEN, EMIT);
  - `SHA512_BLOCK_W`=1024, `SHA512_WORD_W`=64, `SHA512_WORDS`=16;
  - `SHA512_MARKER`=64'h8000_0000_0000_0000.
- One sub-module, `sha512_pad_lastword`: combinational byte masking and marker insertion from (data, bytes).

## Test plan
- "abc": one word 0x6162_6300_0000_0000, bytes=3, last → one block. Word 0 = 0x6162_6380_0000_0000, words 1–14 = 0, word 15 = 0x18; first=last=1.
- Empty message: a single last word with bytes=0 → word 0 = 0x8000_0000_0000_0000, words 1–15 = 0; first=last=1.
- 112-byte message (14 full words, last on the 14th) → two blocks. Block 1: word 14 = marker, word 15 = 0, first=1, last=0. Block 2: words 0–14 = 0, word 15 = 0x380, first=0, last=1.
- 128-byte message of 16 full words → block 1 is the raw data (first=1, last=0). Block 2: word 0 = marker, word 15 = 0x400, last=1.
- Hold `out_ready_i`=0 for 10 cycles during EMIT → `out_valid_o` and the block stay stable, `in_ready_o` stays 0, no input is lost; a back-to-back second message then starts with first=1.
- Assert `rst_i` after 5 words of a message, then send "abc" → output identical to the "abc" case. Separately, a non-last word with bytes=5 → `err_o`=1 and it stays set.
